// File: rtl/clock_rate_monitor_pkg.sv
// Shared constants for the derived-clock rate monitor: counter width, channel map,
// default gate window and per-channel expected edge-count bands.
package clock_mon_pkg;

    localparam int MON_CNT_W = 16;
    localparam int MON_N_CH  = 3;

    localparam int CH_PWM    = 0;
    localparam int CH_CURCTL = 1;
    localparam int CH_I2C    = 2;

    localparam int CLK50_HZ          = 50_000_000;
    localparam int DEF_WINDOW_CYCLES = 50_000;

    localparam int PWM_HZ    = 6_250_000;
    localparam int CURCTL_HZ = 2_000_000;
    localparam int I2C_HZ    = 400_000;

    // Expected rising edges of a clock at hz over one default gate window.
    function automatic int unsigned exp_count(input int unsigned hz);
        return hz / (CLK50_HZ / DEF_WINDOW_CYCLES);
    endfunction

    // Band is +/-1 % plus one count, so a partial edge in the first window still passes.
    function automatic logic [MON_CNT_W-1:0] band_lo(input int unsigned exp_cnt);
        return MON_CNT_W'(exp_cnt - exp_cnt / 100 - 1);
    endfunction

    function automatic logic [MON_CNT_W-1:0] band_hi(input int unsigned exp_cnt);
        return MON_CNT_W'(exp_cnt + exp_cnt / 100 + 1);
    endfunction

    localparam logic [MON_N_CH*MON_CNT_W-1:0] DEF_EXP_MIN = {
        band_lo(exp_count(I2C_HZ)),
        band_lo(exp_count(CURCTL_HZ)),
        band_lo(exp_count(PWM_HZ))
    };

    localparam logic [MON_N_CH*MON_CNT_W-1:0] DEF_EXP_MAX = {
        band_hi(exp_count(I2C_HZ)),
        band_hi(exp_count(CURCTL_HZ)),
        band_hi(exp_count(PWM_HZ))
    };

endpackage

// File: rtl/clock_rate_monitor_if.sv
// Monitored clocks, fault clear and measurement results of the clock rate monitor.
interface clock_rate_monitor_if
    import clock_mon_pkg::*;
#(
    parameter int N_CH  = MON_N_CH,
    parameter int CNT_W = MON_CNT_W
);

    logic [N_CH-1:0]       mon_clk;
    logic                  fault_clear;
    logic [N_CH*CNT_W-1:0] meas_count;
    logic                  meas_valid;
    logic [N_CH-1:0]       clk_ok;
    logic                  all_ok;
    logic [N_CH-1:0]       fault_sticky;

    modport master (
        output mon_clk, fault_clear,
        input  meas_count, meas_valid, clk_ok, all_ok, fault_sticky
    );

    modport slave (
        input  mon_clk, fault_clear,
        output meas_count, meas_valid, clk_ok, all_ok, fault_sticky
    );

endinterface

// File: rtl/clock_rate_monitor_sync.sv
// Two-flop synchronizer for one asynchronous monitored clock, followed by a
// rising-edge detector producing a single-cycle pulse in the CLOCK_50 domain.
module clk_edge_sync (
    input  logic CLOCK_50,
    input  logic reset_n,
    input  logic async_in,
    output logic edge_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign edge_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/clock_rate_monitor.sv
// Counts rising edges of each monitored clock over a fixed CLOCK_50 window and
// flags channels whose count falls outside the expected band.
module clock_rate_monitor
    import clock_mon_pkg::*;
#(
    parameter int                    N_CH          = MON_N_CH,
    parameter int                    CNT_W         = MON_CNT_W,
    parameter int                    WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter logic [N_CH*CNT_W-1:0] EXP_MIN       = '0,
    parameter logic [N_CH*CNT_W-1:0] EXP_MAX       = '1
) (
    input logic                 CLOCK_50,
    input logic                 reset_n,
    clock_rate_monitor_if.slave mon
);

    localparam int               WIN_W    = $clog2(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    logic [WIN_W-1:0] r_win;
    logic             w_tc;
    logic [N_CH-1:0]  w_edge;
    logic [CNT_W-1:0] r_cnt      [N_CH];
    logic [CNT_W-1:0] w_cnt_next [N_CH];
    logic [CNT_W-1:0] r_meas     [N_CH];
    logic [N_CH-1:0]  w_in_band;
    logic [N_CH-1:0]  w_sticky_set;
    logic [N_CH-1:0]  r_clk_ok;
    logic [N_CH-1:0]  r_sticky;
    logic             r_valid;
    logic             r_all_ok;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clk_edge_sync u_sync (
            .CLOCK_50   (CLOCK_50),
            .reset_n    (reset_n),
            .async_in   (mon.mon_clk[g]),
            .edge_pulse (w_edge[g])
        );
        assign mon.meas_count[g*CNT_W +: CNT_W] = r_meas[g];
    end

    assign w_tc = (r_win == WIN_LAST);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_win <= '0;
        end else begin
            r_win <= w_tc ? '0 : r_win + 1'b1;
        end
    end

    // Saturating next count; an edge landing on tc is folded into the closing window.
    always_comb begin
        w_in_band = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_cnt_next[i] = r_cnt[i];
            if (w_edge[i] && (r_cnt[i] != '1)) begin
                w_cnt_next[i] = r_cnt[i] + 1'b1;
            end
            w_in_band[i] = (w_cnt_next[i] >= EXP_MIN[i*CNT_W +: CNT_W]) &&
                           (w_cnt_next[i] <= EXP_MAX[i*CNT_W +: CNT_W]);
        end
        w_sticky_set = w_tc ? ~w_in_band : '0;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_cnt[i]  <= '0;
                r_meas[i] <= '0;
            end
            r_clk_ok <= '0;
            r_sticky <= '0;
            r_valid  <= 1'b0;
            r_all_ok <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_cnt[i] <= w_tc ? '0 : w_cnt_next[i];
                if (w_tc) begin
                    r_meas[i] <= w_cnt_next[i];
                end
            end
            if (w_tc) begin
                r_clk_ok <= w_in_band;
            end
            r_valid  <= w_tc;
            r_all_ok <= &r_clk_ok;
            // Set has priority over clear so a fault in the clearing cycle is kept.
            r_sticky <= (mon.fault_clear ? '0 : r_sticky) | w_sticky_set;
        end
    end

    assign mon.meas_valid   = r_valid;
    assign mon.clk_ok       = r_clk_ok;
    assign mon.all_ok       = r_all_ok;
    assign mon.fault_sticky = r_sticky;

endmodule

// File: tb/tb_clock_rate_monitor.sv
// Directed bench: a 16-bit monitor (window 1000, band 38..42) and a 4-bit
// monitor for saturation and tc-edge alignment, driven by divided CLOCK_50 clocks.
module tb_clock_rate_monitor;

    localparam int WIN = 1000;

    logic CLOCK_50 = 1'b0;
    logic reset_n  = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    int   div_a [3] = '{25, 25, 25};
    int   pc_a  [3] = '{0, 0, 0};
    int   div_b0    = 4;
    int   pc_b0     = 0;
    logic [2:0] clk_a  = '0;
    logic       clk_b0 = 1'b0;
    logic       pin_b1 = 1'b0;
    logic       fc_a   = 1'b0;
    logic       fc_b   = 1'b0;

    clock_rate_monitor_if #(.N_CH(3), .CNT_W(16)) mon_a ();
    clock_rate_monitor_if #(.N_CH(3), .CNT_W(4))  mon_b ();

    assign mon_a.mon_clk     = clk_a;
    assign mon_a.fault_clear = fc_a;
    assign mon_b.mon_clk     = {1'b0, pin_b1, clk_b0};
    assign mon_b.fault_clear = fc_b;

    clock_rate_monitor #(
        .N_CH(3), .CNT_W(16), .WINDOW_CYCLES(WIN),
        .EXP_MIN({3{16'd38}}), .EXP_MAX({3{16'd42}})
    ) dut_a (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .mon      (mon_a)
    );

    clock_rate_monitor #(
        .N_CH(3), .CNT_W(4), .WINDOW_CYCLES(WIN),
        .EXP_MIN({3{4'd1}}), .EXP_MAX({3{4'd14}})
    ) dut_b (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .mon      (mon_b)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Divided clocks: period div cycles, one rising edge per period; div 0 holds low.
    always @(negedge CLOCK_50) begin
        for (int i = 0; i < 3; i++) begin
            if (div_a[i] == 0) begin
                pc_a[i]  = 0;
                clk_a[i] = 1'b0;
            end else begin
                pc_a[i]  = (pc_a[i] + 1 >= div_a[i]) ? 0 : pc_a[i] + 1;
                clk_a[i] = (pc_a[i] < div_a[i] / 2);
            end
        end
        pc_b0  = (pc_b0 + 1 >= div_b0) ? 0 : pc_b0 + 1;
        clk_b0 = (pc_b0 < div_b0 / 2);
    end

    function automatic logic [15:0] cnt_a(input int ch);
        return mon_a.meas_count[ch*16 +: 16];
    endfunction

    function automatic logic [3:0] cnt_b(input int ch);
        return mon_b.meas_count[ch*4 +: 4];
    endfunction

    // Advances to the next meas_valid cycle (sampled 1 ns after posedge); cycles = posedges taken.
    task automatic wait_valid(input bit on_b, output int cycles);
        logic v;
        cycles = 0;
        do begin
            @(posedge CLOCK_50);
            #1;
            cycles++;
            v = on_b ? mon_b.meas_valid : mon_a.meas_valid;
        end while (!v && cycles < 2000);
        if (!v) begin
            n_total++;
            $display("FAIL wait_valid_timeout: meas_valid not seen after %0d cycles, required within %0d", cycles, WIN);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        n_total++; if (mon_a.meas_count !== 48'd0) $display("FAIL reset_meas_count: got %h required 0", mon_a.meas_count); else n_pass++;
        n_total++; if (mon_a.meas_valid !== 1'b0) $display("FAIL reset_meas_valid: got %b required 0", mon_a.meas_valid); else n_pass++;
        n_total++; if (mon_a.clk_ok !== 3'b000) $display("FAIL reset_clk_ok: got %b required 000", mon_a.clk_ok); else n_pass++;
        n_total++; if (mon_a.all_ok !== 1'b0) $display("FAIL reset_all_ok: got %b required 0", mon_a.all_ok); else n_pass++;
        n_total++; if (mon_a.fault_sticky !== 3'b000) $display("FAIL reset_sticky: got %b required 000", mon_a.fault_sticky); else n_pass++;
        reset_n = 1'b1;
    endtask

    task automatic test_nominal();
        int cyc;
        wait_valid(1'b0, cyc);
        n_total++; if (cyc != WIN) $display("FAIL first_valid_latency: got %0d required %0d", cyc, WIN); else n_pass++;
        for (int ch = 0; ch < 3; ch++) begin
            n_total++;
            if (cnt_a(ch) < 16'd39 || cnt_a(ch) > 16'd41) $display("FAIL first_window_count ch%0d: got %0d required 39..41", ch, cnt_a(ch));
            else n_pass++;
        end
        @(posedge CLOCK_50); #1;
        n_total++; if (mon_a.meas_valid !== 1'b0) $display("FAIL valid_one_cycle: got %b required 0", mon_a.meas_valid); else n_pass++;
        // One posedge already consumed above, so the next pulse is 999 posedges away.
        wait_valid(1'b0, cyc);
        n_total++; if (cyc != WIN - 1) $display("FAIL valid_period: got %0d required %0d", cyc, WIN - 1); else n_pass++;
        for (int ch = 0; ch < 3; ch++) begin
            n_total++;
            if (cnt_a(ch) !== 16'd40) $display("FAIL nominal_count ch%0d: got %0d required 40", ch, cnt_a(ch));
            else n_pass++;
        end
        n_total++; if (mon_a.clk_ok !== 3'b111) $display("FAIL nominal_clk_ok: got %b required 111", mon_a.clk_ok); else n_pass++;
        n_total++; if (mon_a.all_ok !== 1'b1) $display("FAIL nominal_all_ok: got %b required 1", mon_a.all_ok); else n_pass++;
        n_total++; if (mon_a.fault_sticky !== 3'b000) $display("FAIL nominal_sticky: got %b required 000", mon_a.fault_sticky); else n_pass++;
    endtask

    task automatic test_dead_channel();
        int cyc;
        @(negedge CLOCK_50); div_a[1] = 0;
        wait_valid(1'b0, cyc);
        n_total++; if (mon_a.clk_ok !== 3'b101) $display("FAIL dead_clk_ok: got %b required 101", mon_a.clk_ok); else n_pass++;
        n_total++; if (mon_a.all_ok !== 1'b1) $display("FAIL dead_all_ok_lag: got %b required 1", mon_a.all_ok); else n_pass++;
        @(posedge CLOCK_50); #1;
        n_total++; if (mon_a.all_ok !== 1'b0) $display("FAIL dead_all_ok: got %b required 0", mon_a.all_ok); else n_pass++;
        n_total++; if (mon_a.fault_sticky !== 3'b010) $display("FAIL dead_sticky: got %b required 010", mon_a.fault_sticky); else n_pass++;
        wait_valid(1'b0, cyc);
        n_total++; if (cnt_a(1) !== 16'd0) $display("FAIL dead_count: got %0d required 0", cnt_a(1)); else n_pass++;
        n_total++; if (mon_a.clk_ok !== 3'b101) $display("FAIL dead_clk_ok_2: got %b required 101", mon_a.clk_ok); else n_pass++;
    endtask

    task automatic test_fault_clear();
        int cyc;
        @(negedge CLOCK_50); div_a[1] = 25;
        wait_valid(1'b0, cyc);
        n_total++; if (mon_a.fault_sticky !== 3'b010) $display("FAIL sticky_held: got %b required 010", mon_a.fault_sticky); else n_pass++;
        @(negedge CLOCK_50); fc_a = 1'b1;
        @(negedge CLOCK_50); fc_a = 1'b0;
        n_total++; if (mon_a.fault_sticky !== 3'b000) $display("FAIL sticky_cleared: got %b required 000", mon_a.fault_sticky); else n_pass++;
        wait_valid(1'b0, cyc);
        n_total++; if (mon_a.clk_ok !== 3'b111) $display("FAIL restored_clk_ok: got %b required 111", mon_a.clk_ok); else n_pass++;
        n_total++; if (cnt_a(1) !== 16'd40) $display("FAIL restored_count: got %0d required 40", cnt_a(1)); else n_pass++;
        n_total++; if (mon_a.fault_sticky !== 3'b000) $display("FAIL restored_sticky: got %b required 000", mon_a.fault_sticky); else n_pass++;
    endtask

    task automatic test_clear_vs_set();
        int cyc;
        @(negedge CLOCK_50); div_a[1] = 0;
        wait_valid(1'b0, cyc);
        n_total++; if (mon_a.fault_sticky !== 3'b010) $display("FAIL setwin_pre: got %b required 010", mon_a.fault_sticky); else n_pass++;
        // Hold fault_clear high across the posedge that closes the next (dead) window.
        repeat (WIN - 1) @(posedge CLOCK_50);
        @(negedge CLOCK_50); fc_a = 1'b1;
        @(posedge CLOCK_50); #1;
        n_total++; if (mon_a.meas_valid !== 1'b1) $display("FAIL setwin_align: got %b required 1", mon_a.meas_valid); else n_pass++;
        n_total++; if (mon_a.fault_sticky !== 3'b010) $display("FAIL setwin_sticky: got %b required 010", mon_a.fault_sticky); else n_pass++;
        @(negedge CLOCK_50); fc_a = 1'b0; div_a[1] = 25;
        wait_valid(1'b0, cyc);
        @(negedge CLOCK_50); fc_a = 1'b1;
        @(negedge CLOCK_50); fc_a = 1'b0;
    endtask

    task automatic test_fast_channel();
        int cyc;
        @(negedge CLOCK_50); div_a[0] = 20;
        wait_valid(1'b0, cyc);
        wait_valid(1'b0, cyc);
        n_total++; if (cnt_a(0) !== 16'd50) $display("FAIL fast_count: got %0d required 50", cnt_a(0)); else n_pass++;
        n_total++; if (mon_a.clk_ok !== 3'b110) $display("FAIL fast_clk_ok: got %b required 110", mon_a.clk_ok); else n_pass++;
        n_total++; if (mon_a.fault_sticky[0] !== 1'b1) $display("FAIL fast_sticky: got %b required 1", mon_a.fault_sticky[0]); else n_pass++;
        @(negedge CLOCK_50); div_a[0] = 25;
    endtask

    task automatic test_saturate_and_tc_edge();
        int cyc;
        wait_valid(1'b1, cyc);
        n_total++; if (cnt_b(0) !== 4'd15) $display("FAIL sat_count: got %0d required 15", cnt_b(0)); else n_pass++;
        n_total++; if (mon_b.clk_ok[0] !== 1'b0) $display("FAIL sat_clk_ok: got %b required 0", mon_b.clk_ok[0]); else n_pass++;
        // Pin rises before posedge P+998, so the edge pulse is high during tc (window count 999).
        repeat (WIN - 3) @(posedge CLOCK_50);
        @(negedge CLOCK_50); pin_b1 = 1'b1;
        wait_valid(1'b1, cyc);
        n_total++; if (cyc != 3) $display("FAIL tc_edge_align: got %0d required 3", cyc); else n_pass++;
        n_total++; if (cnt_b(1) !== 4'd1) $display("FAIL tc_edge_counted: got %0d required 1", cnt_b(1)); else n_pass++;
        n_total++; if (cnt_b(0) !== 4'd15) $display("FAIL sat_no_wrap: got %0d required 15", cnt_b(0)); else n_pass++;
        @(negedge CLOCK_50); pin_b1 = 1'b0;
        wait_valid(1'b1, cyc);
        n_total++; if (cnt_b(1) !== 4'd0) $display("FAIL tc_edge_next_window: got %0d required 0", cnt_b(1)); else n_pass++;
    endtask

    task automatic test_reset_mid_window();
        int cyc;
        wait_valid(1'b0, cyc);
        repeat (WIN / 2) @(posedge CLOCK_50);
        #1 reset_n = 1'b0;
        #1;
        n_total++; if (mon_a.meas_count !== 48'd0) $display("FAIL midrst_meas_count: got %h required 0", mon_a.meas_count); else n_pass++;
        n_total++; if (mon_a.clk_ok !== 3'b000) $display("FAIL midrst_clk_ok: got %b required 000", mon_a.clk_ok); else n_pass++;
        n_total++; if (mon_a.all_ok !== 1'b0) $display("FAIL midrst_all_ok: got %b required 0", mon_a.all_ok); else n_pass++;
        n_total++; if (mon_a.fault_sticky !== 3'b000) $display("FAIL midrst_sticky: got %b required 000", mon_a.fault_sticky); else n_pass++;
        n_total++; if (mon_b.meas_count !== 12'd0) $display("FAIL midrst_b_count: got %h required 0", mon_b.meas_count); else n_pass++;
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;
        wait_valid(1'b0, cyc);
        n_total++; if (cyc != WIN) $display("FAIL midrst_valid_latency: got %0d required %0d", cyc, WIN); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_dead_channel();
        test_fault_clear();
        test_clear_vs_set();
        test_fast_channel();
        test_saturate_and_tc_edge();
        test_reset_mid_window();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
